// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address generator: expands one accepted AW/AR command into a per-beat
// address stream (FIXED/INCR/WRAP) and flags illegal commands for SLVERR completion.
module axi4_burst_addr_gen #(
    parameter int unsigned ADDRESS_WIDTH = 64,
    parameter int unsigned DATA_WIDTH    = 1024
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDRESS_WIDTH-1:0] beat_addr,
    output logic [7:0]               beat_idx,
    output logic                     beat_last,
    output logic                     beat_err,
    output logic                     busy
);

    localparam int unsigned MaxSize = $clog2(DATA_WIDTH / 8);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    logic [0:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_q, cur_d;
    logic [ADDRESS_WIDTH-1:0] lower_q, lower_d;
    logic [ADDRESS_WIDTH-1:0] wrap_end_q, wrap_end_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               mode_q, mode_d;
    logic                     err_q, err_d;

    // Command decode, evaluated on the acceptance cycle only.
    logic [ADDRESS_WIDTH-1:0] cmd_bytes;
    logic [ADDRESS_WIDTH-1:0] cmd_wrap_bytes;
    logic [ADDRESS_WIDTH-1:0] cmd_lower;
    logic [11:0]              cmd_page_off;
    logic [16:0]              cmd_total;
    logic                     cmd_size_ok;
    logic                     cmd_wrap_len_ok;
    logic                     cmd_wrap_aligned;
    logic                     cmd_crosses_4k;
    logic                     cmd_err;
    logic [1:0]               cmd_mode;

    always_comb begin
        cmd_bytes        = ADDRESS_WIDTH'(1) << cmd_size;
        cmd_wrap_bytes   = (ADDRESS_WIDTH'(cmd_len) + ADDRESS_WIDTH'(1)) << cmd_size;
        cmd_lower        = cmd_addr & ~(cmd_wrap_bytes - ADDRESS_WIDTH'(1));
        cmd_page_off     = cmd_addr[11:0] & ~(cmd_bytes[11:0] - 12'd1);
        cmd_total        = (17'(cmd_len) + 17'd1) << cmd_size;
        cmd_size_ok      = 32'(cmd_size) <= MaxSize;
        cmd_wrap_len_ok  = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                           (cmd_len == 8'd7) || (cmd_len == 8'd15);
        cmd_wrap_aligned = (cmd_addr & (cmd_bytes - ADDRESS_WIDTH'(1))) == '0;
        cmd_crosses_4k   = (17'(cmd_page_off) + cmd_total) > 17'd4096;
        cmd_err          = (cmd_burst == BurstRsvd) || !cmd_size_ok ||
                           ((cmd_burst == BurstWrap) && (!cmd_wrap_len_ok || !cmd_wrap_aligned)) ||
                           ((cmd_burst == BurstIncr) && cmd_crosses_4k);
        // Reserved burst or oversized beats still walk the address space like INCR.
        cmd_mode         = ((cmd_burst == BurstRsvd) || !cmd_size_ok) ? BurstIncr : cmd_burst;
    end

    // Per-beat address step.
    logic [ADDRESS_WIDTH-1:0] beat_bytes;
    logic [ADDRESS_WIDTH-1:0] incr_next;
    logic [ADDRESS_WIDTH-1:0] wrap_step;
    logic [ADDRESS_WIDTH-1:0] next_addr;

    always_comb begin
        beat_bytes = ADDRESS_WIDTH'(1) << size_q;
        incr_next  = (cur_q & ~(beat_bytes - ADDRESS_WIDTH'(1))) + beat_bytes;
        wrap_step  = cur_q + beat_bytes;
        unique case (mode_q)
            BurstFixed: next_addr = cur_q;
            BurstWrap:  next_addr = (wrap_step == wrap_end_q) ? lower_q : wrap_step;
            default:    next_addr = incr_next;
        endcase
    end

    logic cmd_fire;
    logic beat_fire;

    always_comb begin
        beat_valid = (state_q == StBurst);
        busy       = beat_valid;
        beat_addr  = cur_q;
        beat_idx   = idx_q;
        beat_last  = beat_valid && (idx_q == len_q);
        beat_err   = err_q;
        cmd_ready  = !areset && ((state_q == StIdle) || (beat_valid && beat_ready && beat_last));
        cmd_fire   = cmd_valid && cmd_ready;
        beat_fire  = beat_valid && beat_ready;
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        lower_d    = lower_q;
        wrap_end_d = wrap_end_q;
        idx_d      = idx_q;
        len_d      = len_q;
        size_d     = size_q;
        mode_d     = mode_q;
        err_d      = err_q;
        if (cmd_fire) begin
            state_d    = StBurst;
            cur_d      = cmd_addr;
            lower_d    = cmd_lower;
            wrap_end_d = cmd_lower + cmd_wrap_bytes;
            idx_d      = 8'd0;
            len_d      = cmd_len;
            size_d     = cmd_size;
            mode_d     = cmd_mode;
            err_d      = cmd_err;
        end else if (beat_fire) begin
            if (beat_last) begin
                state_d = StIdle;
            end else begin
                cur_d = next_addr;
                idx_d = idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            lower_q    <= '0;
            wrap_end_q <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            size_q     <= '0;
            mode_q     <= BurstFixed;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            lower_q    <= lower_d;
            wrap_end_q <= wrap_end_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            size_q     <= size_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
        end
    end

endmodule
